inst_pipe_regs: RTL
===================

Name: inst_pipe_regs

Overview:
Instruction-side pipeline register chain for the five-stage CPU: PC register, instruction fetch address, and the IF/ID, ID/EX, EX/MEM and MEM/WB instruction/PC registers. These feed the per-stage instruction buses consumed by the control decoder. The block also contains load-use hazard detection (stall plus bubble insertion) and branch flush. Branches resolve in the MEM stage, off the EX/MEM instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0000, encoding inserted for bubbles/flushes (sll $0,$0,0)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
IM_Addr  out  32  current PC, drives instruction memory address
IM_Inst  in  32  instruction memory data for IM_Addr, same cycle (combinational ROM)
PipeEnable  in  1  global advance enable; 0 freezes every register
BranchTaken  in  1  MEM-stage branch decision (BEQ in EX/MEM and ALU zero)
BranchTarget  in  32  MEM-stage computed branch target
PR_IFID_Inst / PR_IDEX_Inst / PR_EXMEM_Inst / PR_MEMWB_Inst  out  32 each  stage instruction registers
PR_IFID_PC4 / PR_IDEX_PC4 / PR_EXMEM_PC4  out  32 each  PC+4 of the instruction held in that stage
Stall  out  1  load-use stall active this cycle (combinational)
Flush  out  1  branch flush active this cycle (combinational; equals BranchTaken & PipeEnable)

Behaviour:
- Reset (reset==0, async): PC=RESET_PC; all *_Inst=NOP_INST; all *_PC4=0. Stall and Flush are derived and read 0 once the registers are cleared.
- Field extraction: opcode [31:26], rs [25:21], rt [20:16]. Opcodes come from the shared package: ALUOP 6'b000000, LW 6'b100011, SW 6'b101011, BEQ 6'b000100.
- Hazard detection (combinational):
  - Condition: IDEX.opcode==LW, IDEX.rt!=0, and either
    - IDEX.rt==IFID.rs, or
    - IDEX.rt==IFID.rt with IFID.opcode in {ALUOP, SW, BEQ}.
  - Stall = hazard & ~Flush.
- Per rising edge when PipeEnable==1, priority Flush > Stall > normal:
  - Flush:
    - PC <= BranchTarget.
    - IFID, IDEX, EXMEM Inst <= NOP_INST and their PC4 <= 0.
    - MEMWB <= old EXMEM (the branch itself retires).
  - Stall:
    - PC and IFID hold.
    - IDEX Inst <= NOP_INST, IDEX PC4 <= 0.
    - EXMEM <= IDEX; MEMWB <= EXMEM.
  - Normal:
    - PC <= PC+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
    - IFID <= {IM_Inst, PC+4}; IDEX <= IFID; EXMEM <= IDEX; MEMWB <= EXMEM.
- PipeEnable==0: every register holds; Stall still reflects the hazard; Flush reads 0. A BranchTaken seen while frozen is not lost, because it stays asserted from the held EX/MEM contents.
- Latency: a fetched instruction reaches PR_IFID after 1 edge and PR_MEMWB after 4 edges absent stalls.
- Branch penalty: 3 bubbles. Load-use penalty: 1 bubble.
- Hazard detection uses only rs/rt compares. A NOP in IDEX never stalls, because its rt is 0.
- Reset asserted mid-operation clears immediately regardless of clock. First fetch after deassertion is at RESET_PC.
- PC low two bits: BranchTarget is used as given. Word alignment is the producer's responsibility; assertion in the bench.

Decomposition:
- Shared package: OP_ALUOP, OP_LW, OP_SW, OP_BEQ, NOP_INST, field-position constants. The Inst_opcode/rs/rt extraction macros move into the same package for reuse by the control decoder.
- One sub-module: hazard_detect, combinational. Inputs: PR_IFID_Inst, PR_IDEX_Inst, BranchTaken. Outputs: Stall, Flush.
- Stage registers stay inline in inst_pipe_regs.

Test Plan:
- Reset/straight-line: release reset, ROM holds 0x20+4k at 4k for 6 cycles -> IM_Addr 0,4,8,...; after edge 4 PR_MEMWB_Inst=ROM[0]; PR_IFID_PC4=4 after edge 1.
- Load-use stall: lw $2,0($1) then add $3,$2,$4 -> Stall=1 for exactly one cycle; PC holds for one edge; PR_IDEX_Inst=0 on the following cycle; add reaches EXMEM two edges after lw.
- No false stall: lw $2 then add $3,$5,$6, and lw $0 then add $3,$0,$0 -> Stall stays 0 in both cases.
- Branch flush: beq at 0x10 with BranchTaken=1 and BranchTarget=0x40 when the beq is in EX/MEM -> next edge PC=0x40; IFID/IDEX/EXMEM Inst=0; MEMWB=beq.
- Flush beats stall: load-use pair in IFID/IDEX while BranchTaken=1 -> Stall=0, Flush=1, PC=BranchTarget, both flushed.
- Freeze and async reset: PipeEnable=0 for 3 cycles -> all outputs constant. Then reset pulses low between clock edges -> outputs clear immediately; IM_Addr=RESET_PC.

Source files
------------

// File: rtl/inst_pipe_regs_pkg.sv
// Shared definitions for the instruction-side pipeline of the five-stage CPU.
// Holds the opcode encodings, the bubble encoding, instruction field positions
// and field-extraction helpers reused by the control decoder.
package inst_pipe_regs_pkg;

    // Opcode encodings (instruction bits [31:26])
    localparam logic [5:0] OP_ALUOP = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // Bubble / flush encoding: sll $0,$0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Field positions
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;

    // Per-cycle action applied to the whole register chain
    typedef enum logic [1:0] {
        ActHold,
        ActNormal,
        ActStall,
        ActFlush
    } pipe_act_e;

    function automatic logic [5:0] inst_opcode(input logic [31:0] inst);
        return inst[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [4:0] inst_rs(input logic [31:0] inst);
        return inst[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] inst_rt(input logic [31:0] inst);
        return inst[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/inst_pipe_regs_hazard_detect.sv
// Load-use hazard detection and branch flush generation (combinational).
// Ports:
//   ifid_inst_i     instruction currently in IF/ID
//   idex_inst_i     instruction currently in ID/EX
//   branch_taken_i  MEM-stage branch decision
//   pipe_enable_i   global advance enable; a frozen pipe never flushes
//   stall_o         load-use stall, suppressed while a flush is active
//   flush_o         branch flush this cycle
module inst_pipe_regs_hazard_detect
    import inst_pipe_regs_pkg::*;
(
    input  logic [31:0] ifid_inst_i,
    input  logic [31:0] idex_inst_i,
    input  logic        branch_taken_i,
    input  logic        pipe_enable_i,
    output logic        stall_o,
    output logic        flush_o
);

    logic [5:0] ifid_op;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic [5:0] idex_op;
    logic [4:0] idex_rt;
    logic       ifid_reads_rt;
    logic       hazard;

    // Only opcode/rs/rt take part in the compare
    logic unused_fields;
    assign unused_fields = ^{ifid_inst_i[15:0], idex_inst_i[25:21], idex_inst_i[15:0]};

    always_comb begin
        ifid_op = inst_opcode(ifid_inst_i);
        ifid_rs = inst_rs(ifid_inst_i);
        ifid_rt = inst_rt(ifid_inst_i);
        idex_op = inst_opcode(idex_inst_i);
        idex_rt = inst_rt(idex_inst_i);

        // rt is a source operand only for R-type, stores and branches
        ifid_reads_rt = (ifid_op == OP_ALUOP) || (ifid_op == OP_SW) || (ifid_op == OP_BEQ);

        hazard = 1'b0;
        // A load into $0 never produces a value worth waiting for
        if ((idex_op == OP_LW) && (idex_rt != 5'd0)) begin
            if (idex_rt == ifid_rs) begin
                hazard = 1'b1;
            end else if ((idex_rt == ifid_rt) && ifid_reads_rt) begin
                hazard = 1'b1;
            end
        end

        flush_o = branch_taken_i & pipe_enable_i;
        stall_o = hazard & ~flush_o;
    end

endmodule

// File: rtl/inst_pipe_regs.sv
// Instruction-side pipeline register chain: PC, IF/ID, ID/EX, EX/MEM and MEM/WB
// instruction/PC+4 registers with load-use stall and MEM-stage branch flush.
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   IM_Addr / IM_Inst      instruction memory address (PC) and same-cycle data
//   PipeEnable             0 freezes every register
//   BranchTaken/Target     MEM-stage branch decision and target
//   PR_*_Inst, PR_*_PC4    per-stage instruction and PC+4 registers
//   Stall, Flush           hazard controls active this cycle
module inst_pipe_regs
    import inst_pipe_regs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_WORD
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] IM_Addr,
    input  logic [31:0] IM_Inst,
    input  logic        PipeEnable,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] PR_IFID_Inst,
    output logic [31:0] PR_IDEX_Inst,
    output logic [31:0] PR_EXMEM_Inst,
    output logic [31:0] PR_MEMWB_Inst,
    output logic [31:0] PR_IFID_PC4,
    output logic [31:0] PR_IDEX_PC4,
    output logic [31:0] PR_EXMEM_PC4,
    output logic        Stall,
    output logic        Flush
);

    logic [31:0] pc_q,         pc_d;
    logic [31:0] ifid_inst_q,  ifid_inst_d;
    logic [31:0] ifid_pc4_q,   ifid_pc4_d;
    logic [31:0] idex_inst_q,  idex_inst_d;
    logic [31:0] idex_pc4_q,   idex_pc4_d;
    logic [31:0] exmem_inst_q, exmem_inst_d;
    logic [31:0] exmem_pc4_q,  exmem_pc4_d;
    logic [31:0] memwb_inst_q, memwb_inst_d;

    logic [31:0] pc_plus4;
    pipe_act_e   act;

    inst_pipe_regs_hazard_detect u_hazard_detect (
        .ifid_inst_i    (ifid_inst_q),
        .idex_inst_i    (idex_inst_q),
        .branch_taken_i (BranchTaken),
        .pipe_enable_i  (PipeEnable),
        .stall_o        (Stall),
        .flush_o        (Flush)
    );

    // 32-bit wrap is intended
    assign pc_plus4 = pc_q + 32'd4;

    // Flush outranks stall; Flush is already gated by PipeEnable
    always_comb begin
        act = ActHold;
        if (PipeEnable) begin
            if (Flush) begin
                act = ActFlush;
            end else if (Stall) begin
                act = ActStall;
            end else begin
                act = ActNormal;
            end
        end
    end

    always_comb begin
        pc_d         = pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_pc4_d   = ifid_pc4_q;
        idex_inst_d  = idex_inst_q;
        idex_pc4_d   = idex_pc4_q;
        exmem_inst_d = exmem_inst_q;
        exmem_pc4_d  = exmem_pc4_q;
        memwb_inst_d = memwb_inst_q;

        unique case (act)
            ActFlush: begin
                pc_d         = BranchTarget;
                ifid_inst_d  = NOP_INST;
                ifid_pc4_d   = '0;
                idex_inst_d  = NOP_INST;
                idex_pc4_d   = '0;
                exmem_inst_d = NOP_INST;
                exmem_pc4_d  = '0;
                // The branch itself still retires
                memwb_inst_d = exmem_inst_q;
            end
            ActStall: begin
                // PC and IF/ID hold; a bubble enters ID/EX
                idex_inst_d  = NOP_INST;
                idex_pc4_d   = '0;
                exmem_inst_d = idex_inst_q;
                exmem_pc4_d  = idex_pc4_q;
                memwb_inst_d = exmem_inst_q;
            end
            ActNormal: begin
                pc_d         = pc_plus4;
                ifid_inst_d  = IM_Inst;
                ifid_pc4_d   = pc_plus4;
                idex_inst_d  = ifid_inst_q;
                idex_pc4_d   = ifid_pc4_q;
                exmem_inst_d = idex_inst_q;
                exmem_pc4_d  = idex_pc4_q;
                memwb_inst_d = exmem_inst_q;
            end
            ActHold: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            ifid_inst_q  <= NOP_INST;
            ifid_pc4_q   <= '0;
            idex_inst_q  <= NOP_INST;
            idex_pc4_q   <= '0;
            exmem_inst_q <= NOP_INST;
            exmem_pc4_q  <= '0;
            memwb_inst_q <= NOP_INST;
        end else begin
            pc_q         <= pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pc4_q   <= ifid_pc4_d;
            idex_inst_q  <= idex_inst_d;
            idex_pc4_q   <= idex_pc4_d;
            exmem_inst_q <= exmem_inst_d;
            exmem_pc4_q  <= exmem_pc4_d;
            memwb_inst_q <= memwb_inst_d;
        end
    end

    assign IM_Addr       = pc_q;
    assign PR_IFID_Inst  = ifid_inst_q;
    assign PR_IFID_PC4   = ifid_pc4_q;
    assign PR_IDEX_Inst  = idex_inst_q;
    assign PR_IDEX_PC4   = idex_pc4_q;
    assign PR_EXMEM_Inst = exmem_inst_q;
    assign PR_EXMEM_PC4  = exmem_pc4_q;
    assign PR_MEMWB_Inst = memwb_inst_q;

endmodule
